// File: rtl/sad_pe_line_acc.sv
// sad_pe_line_acc: N_PIX-wide SAD processing-element line with block accumulation and best-candidate tracking
// Ports: clk, rst (sync, active-high); pause freezes all state; clr restarts the search;
//   ref_valid/ref_in shift the reference window; cmp_valid/cur compare one row against it;
//   sad_out/sad_idx/sad_valid report each finished block; best_sad/best_idx/best_valid hold the minimum.
module sad_pe_line_acc #(
    parameter int N_PIX = 8,
    parameter int PIX_W = 8,
    parameter int ROWS  = 8,
    parameter int IDX_W = 8,
    localparam int RW = PIX_W + $clog2(N_PIX),
    localparam int AW = RW + $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pause,
    input  logic                   clr,
    input  logic                   ref_valid,
    input  logic [PIX_W-1:0]       ref_in,
    input  logic                   cmp_valid,
    input  logic [N_PIX*PIX_W-1:0] cur,
    output logic [AW-1:0]          sad_out,
    output logic                   sad_valid,
    output logic [IDX_W-1:0]       sad_idx,
    output logic [AW-1:0]          best_sad,
    output logic [IDX_W-1:0]       best_idx,
    output logic                   best_valid
);
    localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
    logic [N_PIX*PIX_W-1:0] win, d, d_next;
    logic                   v1, v2, sad_pend, last;
    logic [RW-1:0]          row, row_sum;
    logic [AW-1:0]          acc, total;
    logic [CW-1:0]          row_cnt;
    logic [IDX_W-1:0]       cand_cnt;

    always_comb begin
        d_next  = '0;
        row_sum = '0;
        for (int i = 0; i < N_PIX; i++) begin
            d_next[i*PIX_W +: PIX_W] = cur[i*PIX_W +: PIX_W] > win[i*PIX_W +: PIX_W]
                                     ? cur[i*PIX_W +: PIX_W] - win[i*PIX_W +: PIX_W]
                                     : win[i*PIX_W +: PIX_W] - cur[i*PIX_W +: PIX_W];
            row_sum = row_sum + RW'(d[i*PIX_W +: PIX_W]);
        end
    end

    assign total = acc + AW'(row);
    assign last  = row_cnt == CW'(ROWS - 1);
    // A finished block stays pending across a pause and is shown on the first unpaused cycle.
    assign sad_valid = sad_pend & ~pause;

    always_ff @(posedge clk) begin
        if (rst) begin
            win        <= '0;
            d          <= '0;
            row        <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            acc        <= '0;
            row_cnt    <= '0;
            cand_cnt   <= '0;
            sad_out    <= '0;
            sad_idx    <= '0;
            sad_pend   <= 1'b0;
            best_sad   <= '1;
            best_idx   <= '0;
            best_valid <= 1'b0;
        end else if (clr) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            acc        <= '0;
            row_cnt    <= '0;
            cand_cnt   <= '0;
            sad_pend   <= 1'b0;
            best_sad   <= '1;
            best_idx   <= '0;
            best_valid <= 1'b0;
        end else if (!pause) begin
            if (ref_valid)
                win <= {ref_in, win[N_PIX*PIX_W-1:PIX_W]};
            v1 <= cmp_valid;
            if (cmp_valid)
                d <= d_next;
            v2 <= v1;
            if (v1)
                row <= row_sum;
            sad_pend <= v2 & last;
            if (v2) begin
                acc     <= last ? '0 : total;
                row_cnt <= last ? '0 : row_cnt + CW'(1);
                if (last) begin
                    sad_out    <= total;
                    sad_idx    <= cand_cnt;
                    cand_cnt   <= cand_cnt + IDX_W'(1);
                    best_valid <= 1'b1;
                    if (!best_valid || total < best_sad) begin
                        best_sad <= total;
                        best_idx <= cand_cnt;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sad_pe_line_acc.sv
// tb_sad_pe_line_acc: directed vector table plus randomized run against a block-level SAD model
module tb_sad_pe_line_acc;
    localparam int N = 8, PW = 8, ROWS = 2, IW = 8, AW = 12;

    logic            clk = 1'b0;
    logic            rst, pause, clr, ref_valid, cmp_valid;
    logic [PW-1:0]   ref_in;
    logic [N*PW-1:0] cur;
    logic [AW-1:0]   sad_out, best_sad;
    logic            sad_valid, best_valid;
    logic [IW-1:0]   sad_idx, best_idx;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    sad_pe_line_acc #(.N_PIX(N), .PIX_W(PW), .ROWS(ROWS), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .pause(pause), .clr(clr),
        .ref_valid(ref_valid), .ref_in(ref_in), .cmp_valid(cmp_valid), .cur(cur),
        .sad_out(sad_out), .sad_valid(sad_valid), .sad_idx(sad_idx),
        .best_sad(best_sad), .best_idx(best_idx), .best_valid(best_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic p, c, rv;
        logic [7:0] ri;
        logic cv;
        logic [7:0] cu;
        logic sv;
        logic [11:0] so;
        logic [7:0] si;
        logic [11:0] bs;
        logic [7:0] bi;
        logic bb;
    } vec_t;
    vec_t tbl[$];
    logic [11:0] e_so, e_bs;
    logic [7:0]  e_si, e_bi;
    logic        e_bb;

    task automatic e(input int so, input int si, input int bs, input int bi, input int bb);
        e_so = 12'(so); e_si = 8'(si); e_bs = 12'(bs); e_bi = 8'(bi); e_bb = 1'(bb);
    endtask

    task automatic r(input logic p, input logic c, input logic rv, input int ri,
                     input logic cv, input int cu, input logic sv);
        vec_t x;
        x.p = p; x.c = c; x.rv = rv; x.ri = 8'(ri); x.cv = cv; x.cu = 8'(cu); x.sv = sv;
        x.so = e_so; x.si = e_si; x.bs = e_bs; x.bi = e_bi; x.bb = e_bb;
        tbl.push_back(x);
    endtask

    task automatic idle();
        pause = 0; clr = 0; ref_valid = 0; ref_in = '0; cmp_valid = 0; cur = '0;
    endtask

    logic [7:0] win_m[N];
    int acc_m, rows_m, cand_m, bs_m, bi_m;
    bit bv_m;
    typedef struct { int sad, idx, bs, bi; } exp_t;
    exp_t q[$];

    task automatic model_step();
        int rs = 0;
        int a, b;
        if (cmp_valid) begin
            for (int i = 0; i < N; i++) begin
                a = int'(cur[i*PW +: PW]);
                b = int'(win_m[i]);
                rs += a > b ? a - b : b - a;
            end
            acc_m += rs;
            rows_m++;
            if (rows_m == ROWS) begin
                if (!bv_m || acc_m < bs_m) begin
                    bs_m = acc_m;
                    bi_m = cand_m;
                end
                bv_m = 1;
                q.push_back('{acc_m, cand_m, bs_m, bi_m});
                cand_m = (cand_m + 1) % 256;
                acc_m = 0;
                rows_m = 0;
            end
        end
        if (ref_valid) begin
            for (int i = 0; i < N - 1; i++) win_m[i] = win_m[i+1];
            win_m[N-1] = ref_in;
        end
    endtask

    task automatic check_outputs();
        exp_t x;
        chk("sv_while_paused", 32'(sad_valid & pause), 0);
        if (sad_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: sad_out 0x%0h, required no pulse", sad_out);
            end else begin
                x = q.pop_front();
                chk("rnd_sad_out", 32'(sad_out), x.sad);
                chk("rnd_sad_idx", 32'(sad_idx), x.idx);
                chk("rnd_best_sad", 32'(best_sad), x.bs);
                chk("rnd_best_idx", 32'(best_idx), x.bi);
                chk("rnd_best_valid", 32'(best_valid), 1);
            end
        end
    endtask

    initial begin
        vec_t x;
        rst = 1;
        pause = 1'($urandom); clr = 1'($urandom); ref_valid = 1'($urandom); ref_in = 8'($urandom);
        cmp_valid = 1'($urandom); cur = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sad_out", 32'(sad_out), 0);
        chk("rst_sad_valid", 32'(sad_valid), 0);
        chk("rst_sad_idx", 32'(sad_idx), 0);
        chk("rst_best_sad", 32'(best_sad), 32'hFFF);
        chk("rst_best_idx", 32'(best_idx), 0);
        chk("rst_best_valid", 32'(best_valid), 0);
        @(negedge clk);
        rst = 0;
        idle();

        // single block: window of 10s, cur 13
        e(0, 0, 12'hFFF, 0, 0);
        for (int i = 0; i < 8; i++) r(0, 0, 1, 10, 0, 0, 0);
        r(0, 0, 0, 0, 1, 13, 0); r(0, 0, 0, 0, 1, 13, 0); r(0, 0, 0, 0, 0, 0, 0);
        e(48, 0, 48, 0, 1); r(0, 0, 0, 0, 0, 0, 1); r(0, 0, 0, 0, 0, 0, 0);
        // full-scale absolute difference both directions
        for (int i = 0; i < 8; i++) r(0, 0, 1, 255, 0, 0, 0);
        r(0, 0, 0, 0, 1, 0, 0); r(0, 0, 0, 0, 1, 0, 0); r(0, 0, 0, 0, 0, 0, 0);
        e(4080, 1, 48, 0, 1); r(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) r(0, 0, 1, 0, 0, 0, 0);
        r(0, 0, 0, 0, 1, 255, 0); r(0, 0, 0, 0, 1, 255, 0); r(0, 0, 0, 0, 0, 0, 0);
        e(4080, 2, 48, 0, 1); r(0, 0, 0, 0, 0, 0, 1);
        // clr then three back-to-back candidates 48, 16, 16
        e(4080, 2, 12'hFFF, 0, 0); r(0, 1, 0, 0, 0, 0, 0);
        r(0, 0, 0, 0, 1, 3, 0); r(0, 0, 0, 0, 1, 3, 0); r(0, 0, 0, 0, 1, 1, 0);
        e(48, 0, 48, 0, 1); r(0, 0, 0, 0, 1, 1, 1); r(0, 0, 0, 0, 1, 1, 0);
        e(16, 1, 16, 1, 1); r(0, 0, 0, 0, 1, 1, 1); r(0, 0, 0, 0, 0, 0, 0);
        e(16, 2, 16, 1, 1); r(0, 0, 0, 0, 0, 0, 1);
        // pause between rows and inside the pipeline; inputs during pause ignored
        r(0, 0, 0, 0, 1, 3, 0);
        for (int i = 0; i < 3; i++) r(1, 0, 1, 99, 1, 200, 0);
        r(0, 0, 0, 0, 1, 3, 0); r(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) r(1, 0, 1, 99, 1, 200, 0);
        e(48, 3, 16, 1, 1); r(0, 0, 0, 0, 0, 0, 1); r(0, 0, 0, 0, 0, 0, 0);
        // clr mid-block discards the partial block; inputs in clr cycle ignored
        r(0, 0, 0, 0, 1, 1, 0);
        e(48, 3, 12'hFFF, 0, 0); r(0, 1, 1, 77, 1, 5, 0);
        for (int i = 0; i < 3; i++) r(0, 0, 0, 0, 0, 0, 0);
        r(0, 0, 0, 0, 1, 2, 0); r(0, 0, 0, 0, 1, 2, 0); r(0, 0, 0, 0, 0, 0, 0);
        e(32, 0, 32, 0, 1); r(0, 0, 0, 0, 0, 0, 1);
        // shift and compare together: compare sees the pre-shift window
        r(0, 0, 1, 50, 1, 0, 0); r(0, 0, 0, 0, 1, 0, 0); r(0, 0, 0, 0, 0, 0, 0);
        e(50, 1, 32, 0, 1); r(0, 0, 0, 0, 0, 0, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            x = tbl[k];
            @(negedge clk);
            pause = x.p; clr = x.c; ref_valid = x.rv; ref_in = x.ri; cmp_valid = x.cv; cur = {N{x.cu}};
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_sad_valid", k), 32'(sad_valid), 32'(x.sv));
            chk($sformatf("v%0d_sad_out", k), 32'(sad_out), 32'(x.so));
            chk($sformatf("v%0d_sad_idx", k), 32'(sad_idx), 32'(x.si));
            chk($sformatf("v%0d_best_sad", k), 32'(best_sad), 32'(x.bs));
            chk($sformatf("v%0d_best_idx", k), 32'(best_idx), 32'(x.bi));
            chk($sformatf("v%0d_best_valid", k), 32'(best_valid), 32'(x.bb));
        end

        @(negedge clk);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < N; i++) win_m[i] = '0;
        acc_m = 0; rows_m = 0; cand_m = 0; bs_m = 0; bi_m = 0; bv_m = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            check_outputs();
            pause = $urandom_range(0, 4) == 0;
            ref_valid = 1'($urandom);
            ref_in = 8'($urandom);
            cmp_valid = $urandom_range(0, 9) < 7;
            cur = {$urandom, $urandom};
            if (!pause) model_step();
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_outputs();
            idle();
        end
        chk("rnd_all_blocks_delivered", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
